// File: rtl/digit_assemble.sv
// digit_assemble: builds a binary value from a stream of BCD digits.
// The digit count comes first, then the digits arrive most significant first
// over a valid/ready handshake. The result is shown with a one-cycle out_valid.
// Optional feature macro: DIGIT_ASM_LEADZ_CHK_EN. When it is defined, a
// multi-digit number whose first digit is 0 is rejected with err.
module digit_assemble #(
    parameter int MAX_DIGITS = 10,
    parameter int WIDTH      = 34
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       len_in,
    input  logic             dig_valid,
    input  logic [3:0]       dig_in,
    output logic             dig_ready,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             busy,
    output logic             err
);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    localparam logic [3:0] MAX_LEN = 4'(MAX_DIGITS);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] acc_reg, acc_next;
    logic [WIDTH-1:0] out_reg, out_next;
    logic [3:0]       cnt_reg, cnt_next;
    logic [3:0]       len_reg, len_next;
    logic             err_reg, err_next;

    logic [WIDTH-1:0] acc_x10;
    logic [WIDTH-1:0] acc_step;
    logic             bad_digit;
    logic             lead_zero;

    // Multiply by ten with two shifts and an add, then add the new digit.
    assign acc_x10  = (acc_reg << 3) + (acc_reg << 1);
    assign acc_step = acc_x10 + WIDTH'(dig_in);
    assign bad_digit = (dig_in > 4'd9);

`ifdef DIGIT_ASM_LEADZ_CHK_EN
    // A leading zero would make the value shorter than the requested length.
    assign lead_zero = (cnt_reg == 4'd0) && (len_reg > 4'd1) && (dig_in == 4'd0);
`else
    assign lead_zero = 1'b0;
`endif

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            acc_reg   <= '0;
            out_reg   <= '0;
            cnt_reg   <= '0;
            len_reg   <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            out_reg   <= out_next;
            cnt_reg   <= cnt_next;
            len_reg   <= len_next;
            err_reg   <= err_next;
        end
    end

    // Next-state logic. out is captured on entry to DONE, so it holds until the next result.
    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        cnt_next   = cnt_reg;
        len_next   = len_reg;
        err_next   = err_reg;
        out_next   = out_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    len_next = len_in;
                    acc_next = '0;
                    cnt_next = '0;
                    err_next = 1'b0;
                    if (len_in == 4'd0) begin
                        state_next = DONE;
                    end else if (len_in > MAX_LEN) begin
                        state_next = DONE;
                        err_next   = 1'b1;
                    end else begin
                        state_next = LOAD;
                    end
                end
            end
            LOAD: begin
                if (dig_valid) begin
                    if (bad_digit || lead_zero) begin
                        acc_next   = '0;
                        err_next   = 1'b1;
                        state_next = DONE;
                    end else begin
                        acc_next = acc_step;
                        cnt_next = cnt_reg + 4'd1;
                        if (cnt_reg + 4'd1 == len_reg) begin
                            state_next = DONE;
                        end
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (state_next == DONE) begin
            out_next = acc_next;
        end
    end

    assign dig_ready = (state_reg == LOAD);
    assign out_valid = (state_reg == DONE);
    assign busy      = (state_reg != IDLE);
    assign out       = out_reg;
    assign err       = err_reg;

endmodule

// File: doc/digit_assemble.md
Name: digit_assemble

Overview:
- Decimal-to-binary assembler; the inverse direction of the digit-length finder.
- Accepts a digit count and then a stream of BCD digits, most significant digit first, over a valid/ready handshake.
- Accumulates the digits into a 34-bit binary value, then presents it with a one-cycle out_valid pulse.
- Round-trip property: a value built from N digits (leading digit nonzero) measures as length N in the length finder.

Parameters:
- MAX_DIGITS, 10, maximum digit count accepted; 10 digits fit in 34 bits (9,999,999,999 < 2^34).
- WIDTH, 34, accumulator and output width.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  begin a new number; sampled only in IDLE
- len_in  input  4  digit count for the number; sampled with start
- dig_valid  input  1  dig_in holds a digit
- dig_in  input  4  BCD digit; legal values 0..9
- dig_ready  output  1  block accepts a digit this cycle
- out  output  WIDTH  assembled binary value
- out_valid  output  1  one-cycle pulse; out is final
- busy  output  1  high whenever state != IDLE
- err  output  1  high with out_valid when the number was aborted

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE, acc=0, cnt=0.
  - out=0, out_valid=0, dig_ready=0, busy=0, err=0.
  - rst asserted mid-number discards the partial value; no out_valid is issued for it.
- States: IDLE, LOAD, DONE.
- IDLE:
  - dig_ready=0.
  - On start, latch len_in into len_r and clear acc and cnt.
  - If len_in==0, go to DONE with acc=0 and err=0. Zero has length 0.
  - If len_in>MAX_DIGITS, go to DONE with acc=0 and err=1.
  - Otherwise go to LOAD.
- LOAD:
  - dig_ready=1.
  - Digit accepted only when dig_valid && dig_ready.
  - On accept: acc <= acc*10 + dig_in, computed at WIDTH bits; cnt <= cnt+1.
  - When cnt+1==len_r, go to DONE.
  - No accept: hold acc, cnt and state; there is no timeout.
  - Accepted dig_in>9: abort to DONE with err=1, acc forced to 0; further digits are not consumed.
- DONE (exactly one cycle):
  - out_valid=1, out=acc, err as determined; then go to IDLE.
- Output holding:
  - out holds its last value after out_valid deasserts, until the next DONE.
  - err holds its value after out_valid deasserts, until the next start is accepted.
- Latency:
  - out_valid is asserted the cycle after the final digit is accepted.
  - For len_in==0 or an illegal len_in, out_valid is asserted the cycle after start.
  - Minimum throughput: N+2 cycles per N-digit number (start, N digits, DONE).
- start while busy is ignored; no queueing.
- dig_valid in IDLE or DONE is ignored.
- Arithmetic:
  - acc*10 is computed as (acc<<3)+(acc<<1) at WIDTH bits.
  - Overflow cannot occur for len_r<=10 and digits <=9.

Optional Feature:
- Macro: DIGIT_ASM_LEADZ_CHK_EN.
- Defined:
  - When len_r>1, a first accepted digit of 0 aborts to DONE with err=1 and out=0.
  - This guarantees that the digit length of out equals len_r.
- Undefined:
  - Leading zeros are accepted; "007" with len 3 yields out=7 and err=0.

Test Plan:
- start, len_in=4, digits 1,2,3,4 with dig_valid held high → out=1234 and out_valid the cycle after digit 4; busy high for 5 cycles; err=0.
- start, len_in=10, digits 9 x10 → out=9999999999 (0x2540BE3FF); err=0.
- start, len_in=0 → out_valid the next cycle, out=0, err=0; start, len_in=11 → out_valid the next cycle, out=0, err=1.
- len_in=3, digits 5, then dig_valid low 4 cycles, then 0, 7 → out=507; dig_ready stays high while stalled; a start pulse during the stall is ignored.
- len_in=3, digits 1, 12 → err=1, out=0 the cycle after digit 12; rst asserted after the 2nd digit of a 5-digit number → no out_valid, busy=0 the next cycle.
- DIGIT_ASM_LEADZ_CHK_EN defined: len_in=3, digits 0,0,7 → err=1, out=0. Undefined: same stimulus → out=7, err=0.
